// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-write initiator: frame size,
// target register map, FSM state encoding and the debug view of the controller.
package spi_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [6:0] EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  typedef struct packed {
    spi_state_e                state;
    logic [FRAME_BITS-1:0]     rx;
    logic [3:0]                bit_cnt;
  } spi_dbg_t;

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable 8-bit down-counter shared by every phase of a frame; expire is
// high while the count sits at zero, i.e. on the last cycle of a phase.
module spi_phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] len,
  output logic       expire
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = len;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == 8'd0);

endmodule

// File: rtl/spi_controller.sv
// Mode-0 SPI initiator for 16-bit register-write frames with programmable
// chip-select lead/trail/gap timing; also captures cipo for readable targets.
module spi_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_LEAD  = 4,
  parameter int CS_TRAIL = 4,
  parameter int CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       ncs,
  output logic       copi,
  input  logic       cipo,
  output spi_dbg_t   dbg
);

  if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_bad_clk_div
    $error("CLK_DIV must be in 3..255");
  end
  if (CS_LEAD < 3 || CS_LEAD > 255) begin : g_bad_cs_lead
    $error("CS_LEAD must be in 3..255");
  end
  if (CS_TRAIL < 3 || CS_TRAIL > 255) begin : g_bad_cs_trail
    $error("CS_TRAIL must be in 3..255");
  end
  if (CS_GAP < 1 || CS_GAP > 255) begin : g_bad_cs_gap
    $error("CS_GAP must be in 1..255");
  end

  localparam logic [7:0] LEN_DIV   = 8'(CLK_DIV - 1);
  localparam logic [7:0] LEN_LEAD  = 8'(CS_LEAD - 1);
  localparam logic [7:0] LEN_TRAIL = 8'(CS_TRAIL - 1);
  localparam logic [7:0] LEN_GAP   = 8'(CS_GAP - 1);

  // Handshake: a command transfers on any cycle where cmd_valid and cmd_ready
  // are both high; cmd_ready is high only in IDLE, and the command fields are
  // not looked at on any other cycle.

  spi_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic [3:0]            bit_q, bit_d;
  logic                  sclk_q, sclk_d;
  logic                  ncs_q, ncs_d;
  logic                  copi_q, copi_d;
  logic                  done_q, done_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  tmr_load;
  logic [7:0]            tmr_len;
  logic                  tmr_expire;

  spi_phase_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .len    (tmr_len),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    rx_d     = rx_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    ncs_d    = ncs_q;
    copi_d   = copi_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    tmr_load = 1'b0;
    tmr_len  = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          frame_d  = {cmd_write, cmd_addr, cmd_data};
          copi_d   = cmd_write;
          ncs_d    = 1'b0;
          sclk_d   = 1'b0;
          bit_d    = 4'd0;
          state_d  = ST_LEAD;
          tmr_load = 1'b1;
          tmr_len  = LEN_LEAD;
        end
      end
      ST_LEAD: begin
        if (tmr_expire) begin
          sclk_d   = 1'b1;
          state_d  = ST_SHIFT;
          tmr_load = 1'b1;
          tmr_len  = LEN_DIV;
        end
      end
      ST_SHIFT: begin
        // sclk_q tells which half of the bit we are in.
        if (tmr_expire && sclk_q) begin
          rx_d   = {rx_q[FRAME_BITS-2:0], cipo};
          sclk_d = 1'b0;
          tmr_load = 1'b1;
          if (bit_q == 4'(FRAME_BITS - 1)) begin
            state_d = ST_TRAIL;
            tmr_len = LEN_TRAIL;
          end else begin
            frame_d = frame_q << 1;
            copi_d  = frame_q[FRAME_BITS-2];
            bit_d   = bit_q + 4'd1;
            tmr_len = LEN_DIV;
          end
        end else if (tmr_expire) begin
          sclk_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_len  = LEN_DIV;
        end
      end
      ST_TRAIL: begin
        if (tmr_expire) begin
          ncs_d    = 1'b1;
          copi_d   = 1'b0;
          done_d   = 1'b1;
          rdata_d  = rx_q[7:0];
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_len  = LEN_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      rx_q    <= '0;
      bit_q   <= 4'd0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'd0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      copi_q  <= copi_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign sclk      = sclk_q;
  assign ncs       = ncs_q;
  assign copi      = copi_q;
  assign dbg       = '{state: state_q, rx: rx_q, bit_cnt: bit_q};

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: pin waveforms are predicted from the frame timing
// formulas, and a mode-0 register target model checks the resulting writes.
module tb_spi_controller;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       cmd_write = 1'b0;
  logic [6:0] cmd_addr = 7'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       cipo = 1'b0;

  logic       ready_a, busy_a, done_a, sclk_a, ncs_a, copi_a;
  logic       ready_b, busy_b, done_b, sclk_b, ncs_b, copi_b;
  logic [7:0] rdata_a, rdata_b;
  spi_dbg_t   dbg_a, dbg_b;

  spi_controller dut_a (
    .clk(clk), .rst(rst), .cmd_valid(valid_a), .cmd_ready(ready_a),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .busy(busy_a), .done(done_a), .rdata(rdata_a), .sclk(sclk_a),
    .ncs(ncs_a), .copi(copi_a), .cipo(cipo), .dbg(dbg_a)
  );

  spi_controller #(.CLK_DIV(3), .CS_LEAD(3), .CS_TRAIL(3), .CS_GAP(1)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(valid_b), .cmd_ready(ready_b),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .busy(busy_b), .done(done_b), .rdata(rdata_b), .sclk(sclk_b),
    .ncs(ncs_b), .copi(copi_b), .cipo(cipo), .dbg(dbg_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Register target on dut_a's pins: samples through a register, counts rises,
  // commits only complete 16-bit write frames when ncs rises.
  logic [7:0]  p_regs [0:127] = '{default: 8'h00};
  logic [15:0] p_sh = 16'd0;
  int          p_cnt = 0;
  logic        ncs_p = 1'b1, sclk_p = 1'b0;

  always @(posedge clk) begin
    ncs_p  <= ncs_a;
    sclk_p <= sclk_a;
    if (ncs_a === 1'b0 && sclk_a === 1'b1 && sclk_p === 1'b0) begin
      p_sh  <= {p_sh[14:0], copi_a};
      p_cnt <= p_cnt + 1;
    end
    if (ncs_a === 1'b1 && ncs_p === 1'b0) begin
      if (p_cnt == 16 && p_sh[15]) p_regs[p_sh[14:8]] <= p_sh[7:0];
      p_cnt <= 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pins(input bit sel);
    if (sel) return 16'({ncs_b, sclk_b, copi_b, done_b, ready_b, busy_b});
    return 16'({ncs_a, sclk_a, copi_a, done_a, ready_a, busy_a});
  endfunction

  function automatic logic [15:0] rdata_of(input bit sel);
    return sel ? 16'(rdata_b) : 16'(rdata_a);
  endfunction

  // Number of SCLK falls (0..15) that have happened by cycle k.
  function automatic int nfalls(input int k, input int d, input int lead);
    int f0;
    int n;
    f0 = lead + 1 + d;
    if (k < f0) return 0;
    n = (k - f0) / (2 * d) + 1;
    return (n > 15) ? 15 : n;
  endfunction

  // Expected {ncs, sclk, copi, done, ready, busy} at cycle k after acceptance.
  function automatic logic [15:0] model_pins(input int k, input logic [15:0] f,
                                             input int d, input int lead,
                                             input int trail, input int gap);
    int   n_tot;
    int   j;
    logic in_frame, s, c, dn, rdy;
    n_tot    = lead + 31 * d + trail;
    in_frame = (k >= 1 && k <= n_tot);
    j        = k - (lead + 1);
    s        = (j >= 0 && j < 31 * d && (j % (2 * d)) < d);
    c        = in_frame ? f[15 - nfalls(k, d, lead)] : 1'b0;
    dn       = (k == n_tot + 1);
    rdy      = (k >= n_tot + gap + 1);
    return 16'({~in_frame, s, c, dn, rdy, ~rdy});
  endfunction

  task automatic set_valid(input bit sel, input logic v);
    if (sel) valid_b = v; else valid_a = v;
  endtask

  task automatic wait_ready(input bit sel);
    for (int i = 0; i < 300 && !(sel ? ready_b : ready_a); i++) @(negedge clk);
    chk("ready_wait", 16'(sel ? ready_b : ready_a), 16'd1);
  endtask

  task automatic idle_chk(input bit sel, input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_pins", pins(sel), 16'b100010);
    end
  endtask

  // Offers frame f (unless already offered) and checks every cycle up to the
  // return of cmd_ready; optionally re-offers nxt, glitches, or resets mid-frame.
  task automatic run_frame(input bit sel, input logic [15:0] f, input logic [15:0] rxw,
                           input bit pre, input bit hold, input logic [15:0] nxt,
                           input int glitch_k, input int rst_k);
    int d, lead, trail, gap, n_tot, last;
    d     = sel ? 3 : 4;
    lead  = sel ? 3 : 4;
    trail = sel ? 3 : 4;
    gap   = sel ? 1 : 4;
    n_tot = lead + 31 * d + trail;
    last  = (rst_k != 0) ? rst_k + 1 : n_tot + gap + 1;
    if (!pre) begin
      wait_ready(sel);
      {cmd_write, cmd_addr, cmd_data} = f;
      set_valid(sel, 1'b1);
    end
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (rst_k != 0 && k == rst_k + 1) begin
        chk("rst_mid_pins", pins(sel), 16'b100010);
        chk("rst_mid_rdata", rdata_of(sel), 16'd0);
        rst = 1'b0;
        return;
      end
      chk("frame_pins", pins(sel), model_pins(k, f, d, lead, trail, gap));
      if (k == n_tot + 1) chk("rdata", rdata_of(sel), 16'(rxw[7:0]));
      if (k == 1) begin
        if (hold) {cmd_write, cmd_addr, cmd_data} = nxt;
        else set_valid(sel, 1'b0);
      end
      if (glitch_k != 0 && k == glitch_k) begin
        set_valid(sel, 1'b1);
        cmd_data = ~cmd_data;
      end
      if (glitch_k != 0 && k == glitch_k + 1) set_valid(sel, 1'b0);
      if (rst_k != 0 && k == rst_k) rst = 1'b1;
      cipo = rxw[15 - nfalls(k, d, lead)];
    end
  endtask

  initial begin
    logic [15:0] f, rxw;
    logic [7:0]  snap;
    int          addr;

    repeat (3) @(negedge clk);
    chk("reset_pins_a", pins(0), 16'b100010);
    chk("reset_pins_b", pins(1), 16'b100010);
    chk("reset_rdata", rdata_of(0), 16'd0);
    rst = 1'b0;
    idle_chk(0, 10);
    chk("idle_rdata", rdata_of(0), 16'd0);

    rxw = 16'($urandom);
    run_frame(0, {1'b1, PWM_DUTY, 8'hA5}, rxw, 0, 0, 16'd0, 0, 0);
    chk("periph_duty", 16'(p_regs[PWM_DUTY]), 16'h00A5);

    run_frame(0, {1'b1, EN_OUT_7_0, 8'hFF}, 16'($urandom), 0, 1,
              {1'b1, EN_OUT_15_8, 8'h0F}, 0, 0);
    run_frame(0, {1'b1, EN_OUT_15_8, 8'h0F}, 16'($urandom), 1, 0, 16'd0, 0, 0);
    chk("periph_out_lo", 16'(p_regs[EN_OUT_7_0]), 16'h00FF);
    chk("periph_out_hi", 16'(p_regs[EN_OUT_15_8]), 16'h000F);

    run_frame(0, {1'b1, EN_PWM_7_0, 8'h3C}, 16'($urandom), 0, 0, 16'd0, 40, 0);
    idle_chk(0, 10);
    chk("periph_glitch", 16'(p_regs[EN_PWM_7_0]), 16'h003C);

    snap = p_regs[EN_PWM_15_8];
    run_frame(0, {1'b1, EN_PWM_15_8, 8'h77}, 16'hFFFF, 0, 0, 16'd0, 0, 60);
    idle_chk(0, 10);
    chk("periph_trunc", 16'(p_regs[EN_PWM_15_8]), 16'(snap));

    for (int i = 0; i < 5; i++) begin
      addr = $urandom_range(0, 4);
      f    = {1'($urandom_range(0, 1)), 7'(addr), 8'($urandom)};
      snap = p_regs[addr];
      run_frame(0, f, 16'($urandom), 0, 0, 16'd0, 0, 0);
      chk("periph_rand", 16'(p_regs[addr]), f[15] ? 16'(f[7:0]) : 16'(snap));
      idle_chk(0, $urandom_range(0, 5));
    end

    run_frame(1, {1'b1, PWM_DUTY, 8'h5A}, 16'h00C3, 0, 0, 16'd0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      run_frame(1, 16'($urandom), 16'($urandom), 0, 0, 16'd0, 0, 0);
    end
    idle_chk(1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
